// File: rtl/tpu_pkg.sv
// Shared widths and types for the tiny TPU datapath.
package tpu_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = 32;

    typedef logic [DEF_DATA_W-1:0] data_t;
    typedef logic [DEF_ACC_W-1:0]  acc_t;

endpackage

// File: rtl/systolic_pe.sv
// Weight-stationary PE: holds w/act/psum and performs psum_out <= psum_in + act_in*w.
// SYSTOLIC_ACC_SATURATE_EN: clamp psum to all-ones on unsigned overflow instead of wrapping.
module systolic_pe
    import tpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_weight,
    input  logic              valid,
    input  logic [DATA_W-1:0] act_in,
    input  logic [ACC_W-1:0]  psum_in,
    input  logic [DATA_W-1:0] weight_in,
    output logic [DATA_W-1:0] act_out,
    output logic [ACC_W-1:0]  psum_out
);

    logic [DATA_W-1:0]   r_w;
    logic [DATA_W-1:0]   r_act;
    logic [ACC_W-1:0]    r_psum;
    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W-1:0]    w_psum_next;

    assign w_prod = act_in * r_w;

`ifdef SYSTOLIC_ACC_SATURATE_EN
    logic [ACC_W:0] w_sum;
    assign w_sum       = {1'b0, psum_in} + (ACC_W+1)'(w_prod);
    assign w_psum_next = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
`else
    assign w_psum_next = psum_in + ACC_W'(w_prod);
`endif

    // Compute uses the pre-load weight when load_weight and valid coincide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_w    <= '0;
            r_act  <= '0;
            r_psum <= '0;
        end else begin
            if (load_weight) begin
                r_w <= weight_in;
            end
            if (valid) begin
                r_act  <= act_in;
                r_psum <= w_psum_next;
            end
        end
    end

    assign act_out  = r_act;
    assign psum_out = r_psum;

endmodule

// File: rtl/systolic_array_2x2_ws.sv
// 2x2 weight-stationary systolic array: activations shift right, partial sums flow down.
// SYSTOLIC_ACC_SATURATE_EN (in systolic_pe) selects saturating accumulation.
module systolic_array_2x2_ws
    import tpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_weight,
    input  logic              valid,
    input  logic [DATA_W-1:0] a_in1,
    input  logic [DATA_W-1:0] a_in2,
    input  logic [DATA_W-1:0] weight1,
    input  logic [DATA_W-1:0] weight2,
    input  logic [DATA_W-1:0] weight3,
    input  logic [DATA_W-1:0] weight4,
    output logic [DATA_W-1:0] a_out1,
    output logic [DATA_W-1:0] a_out2,
    output logic [ACC_W-1:0]  acc_out1,
    output logic [ACC_W-1:0]  acc_out2
);

    logic [DATA_W-1:0] w_act_00;
    logic [DATA_W-1:0] w_act_10;
    logic [ACC_W-1:0]  w_psum_00;
    logic [ACC_W-1:0]  w_psum_01;

    systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe_00 (
        .clk         (clk),
        .reset       (reset),
        .load_weight (load_weight),
        .valid       (valid),
        .act_in      (a_in1),
        .psum_in     ('0),
        .weight_in   (weight1),
        .act_out     (w_act_00),
        .psum_out    (w_psum_00)
    );

    systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe_01 (
        .clk         (clk),
        .reset       (reset),
        .load_weight (load_weight),
        .valid       (valid),
        .act_in      (w_act_00),
        .psum_in     ('0),
        .weight_in   (weight2),
        .act_out     (a_out1),
        .psum_out    (w_psum_01)
    );

    systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe_10 (
        .clk         (clk),
        .reset       (reset),
        .load_weight (load_weight),
        .valid       (valid),
        .act_in      (a_in2),
        .psum_in     (w_psum_00),
        .weight_in   (weight3),
        .act_out     (w_act_10),
        .psum_out    (acc_out1)
    );

    systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe_11 (
        .clk         (clk),
        .reset       (reset),
        .load_weight (load_weight),
        .valid       (valid),
        .act_in      (w_act_10),
        .psum_in     (w_psum_01),
        .weight_in   (weight4),
        .act_out     (a_out2),
        .psum_out    (acc_out2)
    );

endmodule

// File: tb/tb_systolic_array_2x2_ws.sv
// Directed self-checking bench for systolic_array_2x2_ws with hand-computed results.
module tb_systolic_array_2x2_ws;

    logic        clk;
    logic        reset;
    logic        load_weight;
    logic        valid;
    logic [15:0] a_in1, a_in2;
    logic [15:0] weight1, weight2, weight3, weight4;
    logic [15:0] a_out1, a_out2;
    logic [31:0] acc_out1, acc_out2;

    int unsigned n_tests;
    int unsigned n_fail;

    systolic_array_2x2_ws #(.DATA_W(16), .ACC_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_weight (load_weight),
        .valid       (valid),
        .a_in1       (a_in1),
        .a_in2       (a_in2),
        .weight1     (weight1),
        .weight2     (weight2),
        .weight3     (weight3),
        .weight4     (weight4),
        .a_out1      (a_out1),
        .a_out2      (a_out2),
        .acc_out1    (acc_out1),
        .acc_out2    (acc_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d)", tag, got, got, exp, exp);
        end
    endtask

    // Inputs change #1 after the edge; outputs are sampled at the same point.
    task automatic step(input logic [15:0] x1, input logic [15:0] x2);
        a_in1 = x1;
        a_in2 = x2;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        a_in1 = '0;
        a_in2 = '0;
    endtask

    task automatic idle(input int unsigned n);
        valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_w(input logic [15:0] k1, input logic [15:0] k2,
                          input logic [15:0] k3, input logic [15:0] k4);
        weight1 = k1; weight2 = k2; weight3 = k3; weight4 = k4;
        load_weight = 1'b1;
        @(posedge clk);
        #1;
        load_weight = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] hold1, hold2;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0;
        load_weight = 1'b0;
        valid = 1'b0;
        a_in1 = '0; a_in2 = '0;
        weight1 = '0; weight2 = '0; weight3 = '0; weight4 = '0;
        #12;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_acc1", acc_out1, 32'd0);
        check("reset_aout1", {16'd0, a_out1}, 32'd0);

        // Basic matmul: A=[[11,21],[12,22]], W=[[3,5],[4,6]].
        load_w(16'd3, 16'd5, 16'd4, 16'd6);
        step(16'd11, 16'd0);
        step(16'd12, 16'd21);
        check("mm_c00", acc_out1, 32'd117);
        check("mm_aout1_s2", {16'd0, a_out1}, 32'd11);
        step(16'd0, 16'd22);
        check("mm_c10", acc_out1, 32'd124);
        check("mm_c01", acc_out2, 32'd181);
        check("mm_aout2_s3", {16'd0, a_out2}, 32'd21);
        step(16'd0, 16'd0);
        check("mm_c11", acc_out2, 32'd192);
        check("mm_aout2_s4", {16'd0, a_out2}, 32'd22);

        // Same matmul with stalls; outputs must hold through each gap.
        do_reset();
        load_w(16'd3, 16'd5, 16'd4, 16'd6);
        step(16'd11, 16'd0);
        idle(2);
        step(16'd12, 16'd21);
        hold1 = acc_out1;
        idle(3);
        check("st_hold_c00", acc_out1, hold1);
        check("st_c00", acc_out1, 32'd117);
        step(16'd0, 16'd22);
        hold2 = acc_out2;
        idle(1);
        check("st_c10", acc_out1, 32'd124);
        check("st_hold_c01", acc_out2, hold2);
        check("st_c01", acc_out2, 32'd181);
        idle(2);
        step(16'd0, 16'd0);
        check("st_c11", acc_out2, 32'd192);

        // Asynchronous reset mid-operation, between clock edges.
        step(16'd9, 16'd9);
        #2;
        reset = 1'b0;
        #1;
        check("ar_acc1", acc_out1, 32'd0);
        check("ar_acc2", acc_out2, 32'd0);
        check("ar_aout1", {16'd0, a_out1}, 32'd0);
        check("ar_aout2", {16'd0, a_out2}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        // Weights were cleared, so products stay zero.
        step(16'd5, 16'd5);
        step(16'd5, 16'd5);
        step(16'd5, 16'd5);
        check("ar_wclr_acc1", acc_out1, 32'd0);
        check("ar_wclr_acc2", acc_out2, 32'd0);

        // Activation passthrough.
        do_reset();
        step(16'd7, 16'd0);
        check("pt_a1_s1", {16'd0, a_out1}, 32'd0);
        step(16'd0, 16'd0);
        check("pt_a1_s2", {16'd0, a_out1}, 32'd7);
        step(16'd0, 16'd0);
        check("pt_a1_s3", {16'd0, a_out1}, 32'd0);
        step(16'd0, 16'd7);
        step(16'd0, 16'd0);
        check("pt_a2_s2", {16'd0, a_out2}, 32'd7);

        // Weight reload concurrent with compute: PE(0,0) psum seen on acc_out1 a step later.
        do_reset();
        load_w(16'd3, 16'd5, 16'd4, 16'd6);
        weight1 = 16'd10;
        load_weight = 1'b1;
        step(16'd2, 16'd0);
        load_weight = 1'b0;
        step(16'd2, 16'd0);
        check("wr_old_w", acc_out1, 32'd6);
        step(16'd0, 16'd0);
        check("wr_new_w", acc_out1, 32'd20);

        // Overflow: p = 0xFFFE0001 per PE; two products summed exceed 2^32-1.
        do_reset();
        load_w(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        step(16'hFFFF, 16'hFFFF);
        check("ov_acc1_s1", acc_out1, 32'hFFFE0001);
        step(16'hFFFF, 16'hFFFF);
        check("ov_acc2_s2", acc_out2, 32'hFFFE0001);
`ifdef SYSTOLIC_ACC_SATURATE_EN
        check("ov_acc1_s2", acc_out1, 32'hFFFFFFFF);
`else
        check("ov_acc1_s2", acc_out1, 32'hFFFC0002);
`endif
        step(16'hFFFF, 16'hFFFF);
`ifdef SYSTOLIC_ACC_SATURATE_EN
        check("ov_acc2_s3", acc_out2, 32'hFFFFFFFF);
`else
        check("ov_acc2_s3", acc_out2, 32'hFFFC0002);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
